// File: rtl/blake2_cmd_tx.sv
// Streams one BLAKE2 hash job to a block-oriented hash device: a 10-byte CONF header,
// then 64-byte blocks of payload (zero padded), each block gated by the device's ready.
module blake2_cmd_tx (
  input  logic        clk,
  input  logic        nreset,
  input  logic        start_i,
  input  logic [5:0]  kk_i,
  input  logic [5:0]  nn_i,
  input  logic [63:0] ll_i,
  input  logic        msg_v_i,
  input  logic [7:0]  msg_i,
  output logic        msg_ready_o,
  input  logic        ready_v_i,
  output logic        valid_o,
  output logic [1:0]  cmd_o,
  output logic [7:0]  data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [2:0]  state_o
);

  localparam logic [1:0] CMD_CONF  = 2'd0;
  localparam logic [1:0] CMD_START = 2'd1;
  localparam logic [1:0] CMD_DATA  = 2'd2;
  localparam logic [1:0] CMD_LAST  = 2'd3;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CONF     = 3'd1;
  localparam logic [2:0] S_HOLD     = 3'd2;
  localparam logic [2:0] S_WAIT_RDY = 3'd3;
  localparam logic [2:0] S_BLOCK    = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0]  state;
  logic [5:0]  nn_q;
  logic [63:0] ll_sh;
  logic [63:0] rem;
  logic [3:0]  conf_cnt;
  logic        hold_cnt;
  logic [5:0]  idx;
  logic        first_blk;
  logic        last_blk;
  logic [1:0]  cmd_sel;

  // Handshakes: a payload byte moves when msg_v_i & msg_ready_o are both high at a rising
  // edge; a device byte is presented on valid_o for one cycle with no back-pressure, and
  // ready_v_i only gates the start of a 64-byte block.
  assign msg_ready_o = (state == S_BLOCK) && (rem != 64'd0);
  assign state_o     = state;

  always_comb begin
    cmd_sel = CMD_DATA;
    if (idx == 6'd0) begin
      if (first_blk)     cmd_sel = CMD_START;
      else if (last_blk) cmd_sel = CMD_LAST;
    end else if (idx == 6'd1 && first_blk && last_blk) begin
      cmd_sel = CMD_LAST;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= S_IDLE;
      nn_q      <= '0;
      ll_sh     <= '0;
      rem       <= '0;
      conf_cnt  <= '0;
      hold_cnt  <= 1'b0;
      idx       <= '0;
      first_blk <= 1'b0;
      last_blk  <= 1'b0;
      valid_o   <= 1'b0;
      cmd_o     <= '0;
      data_o    <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      cmd_o   <= CMD_DATA;
      data_o  <= '0;
      done_o  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            nn_q      <= nn_i;
            ll_sh     <= ll_i;
            rem       <= ll_i + ((kk_i != 6'd0) ? 64'd64 : 64'd0);
            first_blk <= 1'b1;
            busy_o    <= 1'b1;
            conf_cnt  <= '0;
            valid_o   <= 1'b1;
            cmd_o     <= CMD_CONF;
            data_o    <= {2'b00, kk_i};
            state     <= S_CONF;
          end
        end
        S_CONF: begin
          // conf_cnt is the index of the header byte currently on data_o.
          if (conf_cnt == 4'd9) begin
            hold_cnt <= 1'b0;
            state    <= S_HOLD;
          end else begin
            conf_cnt <= conf_cnt + 4'd1;
            valid_o  <= 1'b1;
            cmd_o    <= CMD_CONF;
            if (conf_cnt == 4'd0) begin
              data_o <= {2'b00, nn_q};
            end else begin
              data_o <= ll_sh[7:0];
              ll_sh  <= ll_sh >> 8;
            end
          end
        end
        S_HOLD: begin
          if (hold_cnt) state <= S_WAIT_RDY;
          else          hold_cnt <= 1'b1;
        end
        S_WAIT_RDY: begin
          if (ready_v_i) begin
            idx      <= '0;
            last_blk <= (rem <= 64'd64);
            state    <= S_BLOCK;
          end
        end
        S_BLOCK: begin
          // Payload bytes wait on the source; pad bytes go out back-to-back.
          if (rem == 64'd0 || msg_v_i) begin
            valid_o <= 1'b1;
            cmd_o   <= cmd_sel;
            data_o  <= (rem != 64'd0) ? msg_i : 8'h00;
            if (rem != 64'd0) rem <= rem - 64'd1;
            idx <= idx + 6'd1;
            if (idx == 6'd63) begin
              first_blk <= 1'b0;
              hold_cnt  <= 1'b0;
              state     <= last_blk ? S_DONE : S_HOLD;
            end
          end
        end
        S_DONE: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blake2_cmd_tx.sv
// Bench for blake2_cmd_tx: a job-level model predicts the full device byte stream, which a
// per-cycle monitor compares beat by beat; a source and a ready-toggling device surround it.
module tb_blake2_cmd_tx;

  localparam logic [1:0] CONF = 2'd0, START = 2'd1, DATA = 2'd2, LAST = 2'd3;

  logic        clk = 1'b0;
  logic        nreset;
  logic        start_i;
  logic [5:0]  kk_i, nn_i;
  logic [63:0] ll_i;
  logic        msg_v_i;
  logic [7:0]  msg_i;
  logic        msg_ready_o;
  logic        ready_v_i;
  logic        valid_o;
  logic [1:0]  cmd_o;
  logic [7:0]  data_o;
  logic        busy_o;
  logic        done_o;
  logic [2:0]  state_o;

  blake2_cmd_tx dut (
    .clk(clk), .nreset(nreset), .start_i(start_i), .kk_i(kk_i), .nn_i(nn_i), .ll_i(ll_i),
    .msg_v_i(msg_v_i), .msg_i(msg_i), .msg_ready_o(msg_ready_o), .ready_v_i(ready_v_i),
    .valid_o(valid_o), .cmd_o(cmd_o), .data_o(data_o), .busy_o(busy_o), .done_o(done_o),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [9:0] exp_q[$];
  logic [7:0] src_q[$];
  logic [7:0] pay[$];
  logic [9:0] beat_log[$];
  int         beat_cyc[$];
  int cyc = 0, beats_job = 0, done_cnt = 0, popped = 0;
  int gap = 0, ready_wait = 0, vprob = 100, stall_at = -1, stall_left = 0;
  logic ready_seen = 1'b1;
  logic pend = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Device side: compare every beat, drop ready after each block for a while.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!nreset) continue;
      if (ready_wait > 0) begin
        ready_wait--;
        if (ready_wait == 0) ready_v_i = 1'b1;
      end
      if (ready_v_i) ready_seen = 1'b1;
      if (valid_o) begin
        if (beats_job > 10 && (beats_job - 10) % 64 == 0)
          chk("ready_before_block", ready_seen, 1'b1);
        if (exp_q.size() == 0) begin
          chk("extra_beat", {cmd_o, data_o}, 10'h3ff);
        end else begin
          e = exp_q.pop_front();
          chk("beat", {cmd_o, data_o}, e);
        end
        beat_log.push_back({cmd_o, data_o});
        beat_cyc.push_back(cyc);
        beats_job++;
        if (beats_job > 10 && (beats_job - 10) % 64 == 0) begin
          ready_v_i  = 1'b0;
          ready_wait = gap + 1;
          ready_seen = 1'b0;
        end
      end
      if (done_o) begin
        done_cnt++;
        chk("done_busy_clear", busy_o, 1'b0);
      end
    end
  end

  // Payload source: a byte leaves the queue once it was offered while msg_ready_o was high.
  initial begin
    logic [7:0] tmp;
    forever begin
      @(negedge clk);
      if (!nreset) begin
        pend = 1'b0;
        msg_v_i = 1'b0;
        continue;
      end
      if (pend) begin
        tmp = src_q.pop_front();
        popped++;
      end
      if (src_q.size() > 0 && stall_at >= 0 && popped == stall_at && stall_left > 0) begin
        msg_v_i = 1'b0;
        stall_left--;
      end else begin
        msg_v_i = (src_q.size() > 0) && ($urandom_range(1, 100) <= vprob);
        msg_i   = (src_q.size() > 0) ? src_q[0] : 8'($urandom);
      end
      pend = msg_v_i && msg_ready_o;
      if (busy_o && src_q.size() == 0) chk("msg_ready_when_empty", msg_ready_o, 1'b0);
    end
  end

  task automatic run_job(input logic [5:0] kk, input logic [5:0] nn, input logic [63:0] ll,
                         input int vp, input int gp, input int st, input bit inj,
                         input bit rnd, input bit now, input int abort_at);
    logic [63:0] pl;
    int nb, p;
    logic [1:0] c;
    bit injected;
    pl = ll + ((kk != 0) ? 64'd64 : 64'd0);
    nb = (pl == 0) ? 1 : int'((pl + 63) / 64);
    if (rnd) begin
      pay.delete();
      for (int i = 0; i < int'(pl); i++) pay.push_back(8'($urandom_range(0, 255)));
    end
    exp_q.delete();
    exp_q.push_back({CONF, 2'b00, kk});
    exp_q.push_back({CONF, 2'b00, nn});
    for (int i = 0; i < 8; i++) exp_q.push_back({CONF, ll[8*i +: 8]});
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < 64; i++) begin
        p = b * 64 + i;
        if (i == 0)                 c = (b == 0) ? START : ((b == nb - 1) ? LAST : DATA);
        else if (i == 1 && nb == 1) c = LAST;
        else                        c = DATA;
        exp_q.push_back({c, (p < int'(pl)) ? pay[p] : 8'h00});
      end
    end
    src_q = pay;
    popped = 0; beats_job = 0; done_cnt = 0;
    beat_log.delete(); beat_cyc.delete();
    vprob = vp; gap = gp; stall_at = st; stall_left = 3; injected = 0;
    if (!now) @(negedge clk);
    start_i = 1'b1; kk_i = kk; nn_i = nn; ll_i = ll;
    @(negedge clk);
    start_i = 1'b0;
    chk("busy_after_start", busy_o, 1'b1);
    for (int t = 0; t < 4000 && done_cnt == 0; t++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (inj && !injected && beats_job >= 40) begin
        start_i = 1'b1; kk_i = 6'd7; ll_i = 64'd9;
        injected = 1;
      end
      if (abort_at > 0 && beats_job >= abort_at) begin
        nreset = 1'b0;
        #1;
        chk("abort_valid", valid_o, 1'b0);
        chk("abort_busy", busy_o, 1'b0);
        chk("abort_msg_ready", msg_ready_o, 1'b0);
        chk("abort_cmd_data", {cmd_o, data_o}, 10'h000);
        repeat (2) @(negedge clk);
        exp_q.delete(); src_q.delete();
        ready_wait = 0; ready_v_i = 1'b1;
        nreset = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_idle", busy_o, 1'b0);
        return;
      end
    end
    start_i = 1'b0;
    chk("done_seen", done_cnt != 0, 1'b1);
    repeat (3) @(negedge clk);
    chk("done_pulses", done_cnt, 1);
    chk("exp_drained", exp_q.size(), 0);
    chk("src_drained", src_q.size(), 0);
    chk("beat_total", beats_job, 10 + 64 * nb);
    chk("busy_clear", busy_o, 1'b0);
  endtask

  initial begin
    nreset = 1'b0; start_i = 1'b0; kk_i = '0; nn_i = '0; ll_i = '0;
    msg_v_i = 1'b0; msg_i = '0; ready_v_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_cmd", cmd_o, 2'd0);
    chk("rst_data", data_o, 8'h00);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_msg_ready", msg_ready_o, 1'b0);

    // Three-byte message; start asserted together with reset release.
    pay = '{8'hAA, 8'hBB, 8'hCC};
    nreset = 1'b1;
    run_job(6'd0, 6'd32, 64'd3, 100, 2, -1, 0, 0, 1, 0);
    chk("v030_conf0", beat_log[0], 10'h000);
    chk("v030_conf1", beat_log[1], 10'h020);
    chk("v030_conf2", beat_log[2], 10'h003);
    chk("v030_conf9", beat_log[9], 10'h000);
    chk("v030_idx0", beat_log[10], {START, 8'hAA});
    chk("v030_idx1", beat_log[11], {LAST, 8'hBB});
    chk("v030_idx2", beat_log[12], {DATA, 8'hCC});
    chk("v030_idx63", beat_log[73], {DATA, 8'h00});

    // Two blocks with the device holding ready low between them.
    run_job(6'd0, 6'd32, 64'd128, 100, 5, -1, 0, 1, 0, 0);
    chk("v031_blk0_cmd", beat_log[10][9:8], START);
    chk("v031_blk1_cmd", beat_log[74][9:8], LAST);
    chk("v031_wait_gap", (beat_cyc[74] - beat_cyc[73]) >= 7, 1'b1);

    // Empty message.
    run_job(6'd0, 6'd32, 64'd0, 100, 2, -1, 0, 1, 0, 0);
    chk("v032_idx0", beat_log[10], {START, 8'h00});
    chk("v032_idx1", beat_log[11], {LAST, 8'h00});

    // Keyed job: key block adds 64 payload bytes.
    run_job(6'd16, 6'd32, 64'd64, 100, 1, -1, 0, 1, 0, 0);
    chk("v033_kk", beat_log[0], 10'h010);
    chk("v033_ll0", beat_log[2], 10'h040);
    chk("v033_ll1", beat_log[3], 10'h000);

    // Source stall at index 10 plus a start request during the block.
    run_job(6'd0, 6'd32, 64'd100, 100, 2, 10, 1, 1, 0, 0);
    chk("v034_gap", beat_cyc[20] - beat_cyc[19], 4);
    chk("v034_idx10_cmd", beat_log[20][9:8], DATA);

    // Reset at block index 20, then a clean job.
    run_job(6'd0, 6'd32, 64'd100, 100, 2, -1, 0, 1, 0, 30);
    run_job(6'd0, 6'd20, 64'd5, 100, 2, -1, 0, 1, 0, 0);

    for (int j = 0; j < 6; j++) begin
      run_job(($urandom_range(0, 1) == 1) ? 6'($urandom_range(1, 63)) : 6'd0,
              6'($urandom_range(1, 63)), 64'($urandom_range(0, 200)),
              $urandom_range(40, 100), $urandom_range(0, 6), -1,
              $urandom_range(0, 1) == 1, 1, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
